// File: rtl/fp_accum_pkg.sv
// fp_accum_pkg: shared FSM state type and FP32 constants for the accumulator controller.
package fp_accum_pkg;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_RESULT,
        ST_CLEAR,
        ST_CHECK,
        ST_ERR
    } state_e;

    localparam logic [31:0] FP_POS_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;
    localparam logic [31:0] FP_EXP_MASK  = 32'h7F80_0000;

    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x & ~FP_SIGN_MASK) == FP_POS_ZERO;
    endfunction

    function automatic logic [31:0] fp_neg(input logic [31:0] x);
        return x ^ FP_SIGN_MASK;
    endfunction

endpackage

// File: rtl/fp_accum_seq_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags; pointers carry one wrap bit.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = wr_q == rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: feeds an FP32 accumulator from an operand stream and returns per-packet sums,
// re-zeroing the accumulator afterwards by adding the negated sum.
module fp_accum_seq
    import fp_accum_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic             acc_en_o,
    output logic [31:0]      acc_summand_o,
    input  logic [31:0]      acc_sum_i,
    output logic             m_valid_o,
    output logic [31:0]      m_data_o,
    output logic [CNT_W-1:0] m_count_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic             err_o
);
    localparam int WW = $clog2(ACC_LAT + 2);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, m_count_q, m_count_d;
    logic [31:0]      summand_q, summand_d, m_data_q, m_data_d;
    logic             acc_en_q, acc_en_d, m_valid_q, m_valid_d, err_q, err_d;
    logic             full, empty, push, pop;
    logic [32:0]      head;

    // Ready is gated by reset so every output reads 0 while rst_n_i is low.
    assign s_ready_o = rst_n_i && !full && state_q != ST_ERR;
    assign push      = s_valid_i && s_ready_o;
    assign pop       = state_q == ST_ACCUM && !empty;

    sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  ({s_last_i, s_data_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        acc_en_d  = 1'b0;
        summand_d = summand_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        err_d     = err_q;
        case (state_q)
            ST_ACCUM: if (pop) begin
                acc_en_d  = 1'b1;
                summand_d = head[31:0];
                cnt_d     = &cnt_q ? cnt_q : cnt_q + 1'b1;
                if (head[32]) begin
                    state_d = ST_DRAIN;
                    wait_d  = WW'(ACC_LAT);
                end
            end
            ST_DRAIN: if (wait_q == '0) begin
                m_data_d  = acc_sum_i;
                m_count_d = cnt_q;
                m_valid_d = 1'b1;
                state_d   = ST_RESULT;
            end else begin
                wait_d = wait_q - 1'b1;
            end
            ST_RESULT: if (m_ready_i) begin
                m_valid_d = 1'b0;
                cnt_d     = '0;
                acc_en_d  = 1'b1;
                summand_d = fp_neg(m_data_q);
                wait_d    = WW'(ACC_LAT);
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: if (wait_q == '0) state_d = ST_CHECK;
                      else wait_d = wait_q - 1'b1;
            // Inf/NaN sums do not cancel, so a non-zero magnitude here is fatal.
            ST_CHECK: if (fp_is_zero(acc_sum_i)) begin
                state_d = ST_ACCUM;
            end else begin
                err_d   = 1'b1;
                state_d = ST_ERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_ACCUM;
            wait_q    <= '0;
            cnt_q     <= '0;
            acc_en_q  <= 1'b0;
            summand_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            acc_en_q  <= acc_en_d;
            summand_q <= summand_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            err_q     <= err_d;
        end
    end

    assign acc_en_o      = acc_en_q;
    assign acc_summand_o = summand_q;
    assign m_valid_o     = m_valid_q;
    assign m_data_o      = m_data_q;
    assign m_count_o     = m_count_q;
    assign err_o         = err_q;
    assign busy_o        = state_q != ST_ACCUM || !empty;

endmodule
